io_input_conditioner: RTL
=========================

// Module: io_input_conditioner
// PURPOSE
//   Conditions the board's raw slide switches and push buttons before they enter the
//   core's 14-bit io_input_bus. Each bit is synchronised and debounced. Button presses
//   are also captured as sticky events, which the core acknowledges with a clear mask.
//   Sits directly upstream of core.io_input_bus, in the same clock domain as the core.
// PARAMETERS
//   N_SW            10   number of slide switches (io_input_bus[N_SW-1:0])
//   N_BTN           4    number of push buttons (io_input_bus[N_SW+N_BTN-1:N_SW])
//   SYNC_STAGES     2    synchroniser flops per input bit, >=2
//   DEBOUNCE_CYCLES 4    consecutive differing samples before a bit is accepted, >=1
// PORTS
//   clock          in   1          core clock, rising-edge
//   reset          in   1          asynchronous, active-high
//   sw_raw         in   N_SW       raw switches, asynchronous, 1 = on
//   btn_raw_n      in   N_BTN      raw buttons, asynchronous, active-low (0 = pressed)
//   evt_clear      in   N_BTN      one-cycle clear mask for btn_event, from core
//   io_input_bus   out  N_SW+N_BTN {btn_level, sw_level}, debounced, to core
//   btn_event      out  N_BTN      sticky press-event flags
//   event_pending  out  1          |btn_event
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - All sync flops, stable levels, counters and btn_event clear to 0.
//   - Buttons are inverted before the synchroniser, so 0 means "released".
//   - io_input_bus = 0, btn_event = 0 and event_pending = 0 while reset is high
//     and on the first edge after release.
//   Synchroniser:
//   - Per bit: a chain of SYNC_STAGES flops. sync_q is the last stage.
//   - No logic between stages.
//   Debounce (independent per bit; counter width $clog2(DEBOUNCE_CYCLES+1)):
//   - sync_q == stable: cnt <= 0.
//   - sync_q != stable and cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - sync_q != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync_q, cnt <= 0.
//   - Any glitch back to the old level before acceptance restarts the count from 0.
//   - Latency: a clean raw step is first sampled at edge E0. The bus bit changes at
//     edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1 and is visible after that edge.
//   - With the defaults this is 5 edges after E0.
//   - Pulses shorter than DEBOUNCE_CYCLES synced samples never reach the bus.
//   Event capture:
//   - press = stable_btn rising (0->1) this edge. A release produces no event.
//   - btn_event[i] <= press[i] | (btn_event[i] & ~evt_clear[i]).
//   - A press and a clear in the same cycle: set wins, so the flag stays 1.
//   - Clearing an already-clear bit has no effect.
//   - A second press while the flag is set leaves it 1; presses are not counted.
//   - event_pending is combinational OR of the registered btn_event, with no extra latency.
//   Outputs:
//   - All outputs are registered or a pure OR of registers.
//   - No combinational path from any raw input to any output.
//   Reset mid-operation:
//   - Asserting reset aborts any count in progress and clears pending events
//     immediately (asynchronous).
//   - After release, an input still held active is re-accepted after the full latency.
//   - A button still held through reset release generates a fresh event on acceptance.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock)
//   1 Reset, sw_raw=10'h3FF held during reset -> io_input_bus==0 during reset.
//     After release, bus[9:0]==10'h3FF exactly 5 edges after first sampling edge.
//   2 btn_raw_n[0] 1->0->1 glitch, low for 3 cycles -> bus[10] stays 0, btn_event stays 0.
//     Low for 6 cycles -> bus[10]=1 for one accepted interval, btn_event==4'b0001,
//     event_pending=1.
//   3 Hold btn0 pressed, then release -> btn_event stays 4'b0001 (release adds nothing).
//     Then evt_clear=4'b0001 for 1 cycle -> btn_event==0, event_pending==0 on next edge.
//   4 Btn2 acceptance edge coincides with evt_clear=4'b0100 -> btn_event[2]==1 (set wins).
//     Simultaneous accepted presses on btn1 and btn3 -> btn_event==4'b1010.
//   5 Sw5 toggles every 2 cycles for 40 cycles -> bus[5] never changes.
//     Then a steady 1 -> bus[5]=1 after 5 edges.
//   6 Btn0 counting (cnt==2) and btn_event=4'b0010 set, then async reset pulse mid-cycle
//     -> bus/btn_event/event_pending read 0 before the next clock edge.
//     Btn0 still held -> event re-fires 5 edges after release.

Source files
------------

// File: rtl/io_input_conditioner_if.sv
// Raw board inputs, core clear mask and the conditioned bus toward the core.
// The conditioner takes the master side; the board/core environment the slave side.
interface io_input_conditioner_if #(
    parameter int N_SW  = 10,
    parameter int N_BTN = 4
);
    logic [N_SW-1:0]       sw_raw;
    logic [N_BTN-1:0]      btn_raw_n;
    logic [N_BTN-1:0]      evt_clear;
    logic [N_SW+N_BTN-1:0] io_input_bus;
    logic [N_BTN-1:0]      btn_event;
    logic                  event_pending;

    modport master (
        input  sw_raw,
        input  btn_raw_n,
        input  evt_clear,
        output io_input_bus,
        output btn_event,
        output event_pending
    );

    modport slave (
        output sw_raw,
        output btn_raw_n,
        output evt_clear,
        input  io_input_bus,
        input  btn_event,
        input  event_pending
    );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces switches and buttons for the core input bus,
// and latches button presses as sticky events cleared by the core.
module io_input_conditioner #(
    parameter int N_SW            = 10,
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    io_input_conditioner_if.master io
);
    localparam int N_BIT = N_SW + N_BTN;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_BIT-1:0]                  raw;
    logic [SYNC_STAGES-1:0][N_BIT-1:0] sync_r;
    logic [N_BIT-1:0]                  sync_q;
    logic [N_BIT-1:0]                  stable;
    logic [N_BIT-1:0]                  stable_nxt;
    logic [N_BIT-1:0][CNT_W-1:0]       cnt;
    logic [N_BIT-1:0][CNT_W-1:0]       cnt_nxt;
    logic [N_BTN-1:0]                  press;
    logic [N_BTN-1:0]                  btn_event;
    logic [N_BTN-1:0]                  event_nxt;

    // Buttons flipped to active-high so a reset-cleared flop means "released".
    assign raw    = {~io.btn_raw_n, io.sw_raw};
    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        for (int b = 0; b < N_BIT; b++) begin
            if (sync_q[b] != stable[b]) begin
                if (cnt[b] == CNT_LAST) begin
                    stable_nxt[b] = sync_q[b];
                end else begin
                    cnt_nxt[b] = cnt[b] + 1'b1;
                end
            end
        end
    end

    // A press is flagged on the very edge the debounced level rises.
    assign press     = stable_nxt[N_BIT-1:N_SW] & ~stable[N_BIT-1:N_SW];
    assign event_nxt = press | (btn_event & ~io.evt_clear);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable    <= '0;
            cnt       <= '0;
            btn_event <= '0;
        end else begin
            stable    <= stable_nxt;
            cnt       <= cnt_nxt;
            btn_event <= event_nxt;
        end
    end

    assign io.io_input_bus  = stable;
    assign io.btn_event     = btn_event;
    assign io.event_pending = |btn_event;
endmodule
